cia_eclk_bus_ctrl: RTL and testbench
====================================

// Module: cia_eclk_bus_ctrl
// PURPOSE
//  6800-style synchronous bus controller for CIA 8520 access, consuming the 10-phase E-clock enable from the clock generator.
//  Accepts a CPU request and aligns it to the E-clock period (VMA/E window); CPU writes and register-select stay stable through that period.
//  It pulses a one-cycle CIA strobe at end of E-high, captures read data, then returns ack to the CPU. Sits between the CPU bus decoder and the two CIAs.
// PARAMETERS
//  VMA_PHASE      3   eclk index at which VMA is asserted for a synchronised access
//  E_HIGH_FIRST   6   first eclk index of E-high window (E high for phases E_HIGH_FIRST..9)
//  TIMEOUT_CYCLES 32  clk cycles from acceptance to forced bus error (only with CIA_TIMEOUT_EN)
// PORTS
//  clk          in   1   7.09 MHz system clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  eclk         in   10  one-hot E phase enables; eclk[n]=1 during E phase n
//  cpu_req      in   1   CPU access request, level, held until ack/berr
//  cpu_rw       in   1   1=read, 0=write
//  cpu_sel_a    in   1   CIA-A selected
//  cpu_sel_b    in   1   CIA-B selected
//  cpu_rs       in   4   CIA register select
//  cpu_wdata    in   8   write data
//  cpu_rdata    out  8   captured read data, valid with cpu_ack
//  cpu_ack      out  1   one-cycle completion pulse
//  cpu_berr     out  1   one-cycle bus-error pulse
//  vma          out  1   valid memory address
//  cia_e        out  1   E level = |eclk[9:E_HIGH_FIRST]
//  cia_a_en     out  1   CIA-A chip enable
//  cia_b_en     out  1   CIA-B chip enable
//  cia_rw       out  1   registered copy of cpu_rw
//  cia_rs       out  4   registered copy of cpu_rs
//  cia_wdata    out  8   registered copy of cpu_wdata
//  cia_strobe   out  1   one-cycle pulse in eclk[9] cycle of the owned access
//  cia_rdata_a  in   8   CIA-A read data
//  cia_rdata_b  in   8   CIA-B read data
// BEHAVIOUR
//  Reset: all outputs 0 except cia_rw=1; state IDLE.
//  cia_e is combinational from eclk, independent of state.
//  FSM: IDLE -> SYNC -> ACCESS -> DONE -> IDLE.
//  IDLE: cpu_req & (sel_a|sel_b) sampled -> latch rw/rs/wdata/selects into cia_*, go SYNC.
//   A req with no select is ignored.
//  SYNC: when eclk[VMA_PHASE]=1 -> vma<=1 next cycle, cia_a_en/cia_b_en <= latched selects, go ACCESS.
//   A request accepted in the eclk[VMA_PHASE] cycle itself waits for the next E period.
//  ACCESS: in eclk[9] cycle cia_strobe=1, capture cpu_rdata (A if sel_a, else B; both selected -> A).
//   On the following cycle: cpu_ack=1, vma/enables cleared, go DONE.
//   Writes leave cpu_rdata unchanged.
//  DONE: stay until cpu_req=0, then IDLE.
//   No new access is accepted while req is held, which prevents double access.
//  Latency: accepted at phase VMA_PHASE-1 -> ack 8 cycles later; worst case 17 cycles.
//  cpu_req dropped mid-access: CIA cycle completes (no partial E period).
//   cpu_ack suppressed if cpu_req=0 in the ack cycle.
//  Latched inputs are stable from SYNC through ack; later CPU input changes are ignored.
//  reset in any state: immediate IDLE, no strobe/ack emitted that cycle.
//  eclk all-zero (not locked): FSM waits in SYNC, unless CIA_TIMEOUT_EN is defined.
// CONFIGURATION
//  CIA_TIMEOUT_EN defined:
//   A 6-bit counter starts at acceptance and clears in IDLE.
//   If it reaches TIMEOUT_CYCLES while in SYNC or ACCESS: cpu_berr=1 one cycle, vma/enables cleared, no strobe, go DONE.
//  CIA_TIMEOUT_EN undefined: no counter; cpu_berr tied 0.
// STRUCTURE
//  Shared package: state encoding (IDLE/SYNC/ACCESS/DONE) and eclk phase index constants (VMA_PHASE, E_HIGH_FIRST, E_LAST=9).
//  Single flat module; no sub-module (phase decode is a few gates).
// TESTING
//  Read CIA-A, rs=4, cia_rdata_a=8'h5A, req at eclk[1] -> vma from phase 4, strobe at eclk[9], ack next cycle, cpu_rdata=8'h5A.
//  Write CIA-B, wdata=8'hC3, req in eclk[3] cycle -> waits full period; cia_wdata=8'hC3 stable; single strobe; ack 17 cycles after req.
//  Both selects, read, a=8'h11 b=8'h22 -> both enables high, cpu_rdata=8'h11.
//  req held high 30 cycles after ack -> exactly one strobe, stays DONE; req low -> IDLE; next req starts a new access.
//  reset pulse during ACCESS -> no strobe, no ack, all outputs reset next cycle.
//  CIA_TIMEOUT_EN, eclk=0 -> cpu_berr pulse 32 cycles after acceptance, no strobe; without the macro, FSM remains in SYNC.

Source files
------------

// File: rtl/cia_eclk_bus_ctrl_pkg.sv
// Shared definitions for the CIA E-clock bus controller: FSM state encoding
// and the E-clock phase indices used to align CPU accesses.
package cia_eclk_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ECLK_W         = 10;
    localparam int VMA_PHASE      = 3;
    localparam int E_HIGH_FIRST   = 6;
    localparam int E_LAST         = 9;
    localparam int TIMEOUT_CYCLES = 32;

endpackage

// File: rtl/cia_eclk_bus_ctrl.sv
// 6800-style synchronous bus controller aligning CPU accesses to the CIA E clock.
// Optional macro CIA_TIMEOUT_EN adds a bus-error timeout for a stalled access.
module cia_eclk_bus_ctrl
    import cia_eclk_bus_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ECLK_W-1:0]   eclk,
    input  logic                cpu_req,
    input  logic                cpu_rw,
    input  logic                cpu_sel_a,
    input  logic                cpu_sel_b,
    input  logic [3:0]          cpu_rs,
    input  logic [7:0]          cpu_wdata,
    output logic [7:0]          cpu_rdata,
    output logic                cpu_ack,
    output logic                cpu_berr,
    output logic                vma,
    output logic                cia_e,
    output logic                cia_a_en,
    output logic                cia_b_en,
    output logic                cia_rw,
    output logic [3:0]          cia_rs,
    output logic [7:0]          cia_wdata,
    output logic                cia_strobe,
    input  logic [7:0]          cia_rdata_a,
    input  logic [7:0]          cia_rdata_b,
    output state_t              fsm_state
);

    state_t state, state_next;
    logic   accept, sync_go, strobe_hit, timeout_hit, eclk_locked;
    logic   sel_a_q, sel_b_q, ack_pend;

    assign cia_e       = |eclk[E_LAST:E_HIGH_FIRST];
    assign eclk_locked = $onehot(eclk);
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SYNC;
            ST_SYNC:   if (timeout_hit) state_next = ST_DONE;
                       else if (sync_go) state_next = ST_ACCESS;
            ST_ACCESS: if (timeout_hit || strobe_hit) state_next = ST_DONE;
            ST_DONE:   if (!cpu_req) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Strobe and ack are gated by reset so a reset cycle never emits either.
    always_comb begin
        accept     = (state == ST_IDLE) && cpu_req && (cpu_sel_a || cpu_sel_b);
        sync_go    = (state == ST_SYNC) && eclk[VMA_PHASE] && eclk_locked;
        strobe_hit = (state == ST_ACCESS) && eclk[E_LAST] && !timeout_hit;
        cia_strobe = strobe_hit && !reset;
        cpu_ack    = ack_pend && cpu_req && !reset;
    end

`ifdef CIA_TIMEOUT_EN
    logic [5:0] to_cnt;

    // Counts cycles since acceptance; saturates so a stuck DONE cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= 6'd0;
        end else if (state == ST_IDLE) begin
            to_cnt <= accept ? 6'd1 : 6'd0;
        end else if (to_cnt != 6'h3F) begin
            to_cnt <= to_cnt + 6'd1;
        end
    end

    assign timeout_hit = ((state == ST_SYNC) || (state == ST_ACCESS)) &&
                         (to_cnt == 6'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_berr <= 1'b0;
        end else begin
            cpu_berr <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign cpu_berr    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vma       <= 1'b0;
            cia_a_en  <= 1'b0;
            cia_b_en  <= 1'b0;
            cia_rw    <= 1'b1;
            cia_rs    <= 4'd0;
            cia_wdata <= 8'd0;
            cpu_rdata <= 8'd0;
            sel_a_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            ack_pend  <= 1'b0;
        end else begin
            ack_pend <= strobe_hit;
            if (accept) begin
                cia_rw    <= cpu_rw;
                cia_rs    <= cpu_rs;
                cia_wdata <= cpu_wdata;
                sel_a_q   <= cpu_sel_a;
                sel_b_q   <= cpu_sel_b;
            end
            if (sync_go && !timeout_hit) begin
                vma      <= 1'b1;
                cia_a_en <= sel_a_q;
                cia_b_en <= sel_b_q;
            end
            if (strobe_hit || timeout_hit) begin
                vma      <= 1'b0;
                cia_a_en <= 1'b0;
                cia_b_en <= 1'b0;
            end
            // CIA-A wins when both chips are selected.
            if (strobe_hit && cia_rw) begin
                cpu_rdata <= sel_a_q ? cia_rdata_a : cia_rdata_b;
            end
        end
    end

endmodule

// File: tb/tb_cia_eclk_bus_ctrl.sv
// Self-checking bench for cia_eclk_bus_ctrl: timing predicted arithmetically
// from the E-clock phase at acceptance, read data tracked in a scoreboard queue.
module tb_cia_eclk_bus_ctrl;
    import cia_eclk_bus_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] eclk;
    logic       cpu_req, cpu_rw, cpu_sel_a, cpu_sel_b;
    logic [3:0] cpu_rs;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_ack, cpu_berr, vma, cia_e, cia_a_en, cia_b_en, cia_rw, cia_strobe;
    logic [3:0] cia_rs;
    logic [7:0] cia_wdata, cia_rdata_a, cia_rdata_b;
    state_t     fsm_state;

    int   total = 0;
    int   bad = 0;
    int   phase = 0;
    bit   dead = 1'b0;
    logic [7:0] last_rdata = 8'd0;
    logic [7:0] exp_q[$];

    cia_eclk_bus_ctrl dut (
        .clk(clk), .reset(reset), .eclk(eclk),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_sel_a(cpu_sel_a), .cpu_sel_b(cpu_sel_b),
        .cpu_rs(cpu_rs), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_berr(cpu_berr), .vma(vma), .cia_e(cia_e),
        .cia_a_en(cia_a_en), .cia_b_en(cia_b_en), .cia_rw(cia_rw), .cia_rs(cia_rs),
        .cia_wdata(cia_wdata), .cia_strobe(cia_strobe),
        .cia_rdata_a(cia_rdata_a), .cia_rdata_b(cia_rdata_b), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // One clock: advance the E phase just after the edge, then check E level.
    task automatic step();
        logic exp_e;
        @(posedge clk);
        #1;
        phase = (phase + 1) % 10;
        eclk = dead ? 10'd0 : (10'd1 << phase);
        #1;
        exp_e = !dead && (phase >= 6);
        total++;
        if (cia_e !== exp_e) begin
            bad++;
            $display("FAIL cia_e phase=%0d got=%b exp=%b", phase, cia_e, exp_e);
        end
    endtask

    task automatic wait_phase(input int p);
        for (int n = 0; n < 20 && phase != p; n++) step();
    endtask

    // Cycles from acceptance to the first SYNC cycle that sees the VMA phase.
    function automatic int sync_delay(input int p);
        return ((VMA_PHASE - p - 1 + 20) % 10) + 1;
    endfunction

    task automatic run_access(input bit rw, input bit sa, input bit sb, input logic [3:0] rs,
                              input logic [7:0] wd, input logic [7:0] ra, input logic [7:0] rb,
                              input int p, input int hold, input string name);
        int d, strobe_k, strobes, ack_k, vma_k, extra;
        logic a_en_s, b_en_s, rw_s, vma_ack;
        logic [3:0] rs_s;
        logic [7:0] wd_s, rd_got, rd_exp;
        strobe_k = -1; strobes = 0; ack_k = -1; vma_k = -1; extra = 0;
        a_en_s = 0; b_en_s = 0; rw_s = 0; rs_s = 0; wd_s = 0; rd_got = 0; vma_ack = 1'bx;
        wait_phase(p);
        cpu_req = 1; cpu_rw = rw; cpu_sel_a = sa; cpu_sel_b = sb; cpu_rs = rs; cpu_wdata = wd;
        cia_rdata_a = ra; cia_rdata_b = rb;
        d = sync_delay(p);
        exp_q.push_back(rw ? (sa ? ra : rb) : last_rdata);
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            step();
            if (k == 1) begin
                cpu_rw = 1'($urandom); cpu_rs = 4'($urandom); cpu_wdata = 8'($urandom);
            end
            if (vma === 1'b1 && vma_k < 0) vma_k = k;
            if (cia_strobe === 1'b1) begin
                strobes++; strobe_k = k;
                a_en_s = cia_a_en; b_en_s = cia_b_en; rw_s = cia_rw; rs_s = cia_rs; wd_s = cia_wdata;
            end
            if (cpu_ack === 1'b1) begin
                ack_k = k; rd_got = cpu_rdata; vma_ack = vma;
            end
        end
        for (int h = 0; h < hold; h++) begin
            step();
            if (cia_strobe === 1'b1 || cpu_ack === 1'b1 || vma === 1'b1) extra++;
        end
        rd_exp = exp_q.pop_front();
        last_rdata = rd_exp;
        total += 11;
        if (vma_k != d + 1) begin bad++; $display("FAIL %s vma_start got=%0d exp=%0d", name, vma_k, d + 1); end
        if (strobe_k != d + 6) begin bad++; $display("FAIL %s strobe_cycle got=%0d exp=%0d", name, strobe_k, d + 6); end
        if (strobes != 1) begin bad++; $display("FAIL %s strobe_count got=%0d exp=1", name, strobes); end
        if (ack_k != d + 7) begin bad++; $display("FAIL %s ack_cycle got=%0d exp=%0d", name, ack_k, d + 7); end
        if (a_en_s !== sa || b_en_s !== sb) begin bad++; $display("FAIL %s enables got=%b%b exp=%b%b", name, a_en_s, b_en_s, sa, sb); end
        if (rw_s !== rw) begin bad++; $display("FAIL %s cia_rw got=%b exp=%b", name, rw_s, rw); end
        if (rs_s !== rs) begin bad++; $display("FAIL %s cia_rs got=%h exp=%h", name, rs_s, rs); end
        if (wd_s !== wd) begin bad++; $display("FAIL %s cia_wdata got=%h exp=%h", name, wd_s, wd); end
        if (rd_got !== rd_exp) begin bad++; $display("FAIL %s cpu_rdata got=%h exp=%h", name, rd_got, rd_exp); end
        if (vma_ack !== 1'b0) begin bad++; $display("FAIL %s vma_at_ack got=%b exp=0", name, vma_ack); end
        if (extra != 0) begin bad++; $display("FAIL %s activity_while_held got=%0d exp=0", name, extra); end
        if (hold > 0) begin
            total++;
            if (fsm_state !== ST_DONE) begin bad++; $display("FAIL %s held_state got=%0d exp=%0d", name, fsm_state, ST_DONE); end
        end
        cpu_req = 0;
        step();
        total++;
        if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL %s back_to_idle got=%0d exp=%0d", name, fsm_state, ST_IDLE); end
    endtask

    task automatic test_reset();
        reset = 1; cpu_req = 0; cpu_rw = 0; cpu_sel_a = 0; cpu_sel_b = 0; cpu_rs = 0; cpu_wdata = 0;
        cia_rdata_a = 0; cia_rdata_b = 0; phase = 0; eclk = 10'd1;
        repeat (3) step();
        total += 4;
        if ({vma, cia_a_en, cia_b_en, cia_strobe, cpu_ack, cpu_berr} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000000", {vma, cia_a_en, cia_b_en, cia_strobe, cpu_ack, cpu_berr});
        end
        if (cia_rw !== 1'b1) begin bad++; $display("FAIL reset_cia_rw got=%b exp=1", cia_rw); end
        if ({cia_rs, cia_wdata, cpu_rdata} !== 20'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {cia_rs, cia_wdata, cpu_rdata}); end
        if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        reset = 0;
        step();
    endtask

    task automatic test_directed();
        run_access(1, 1, 0, 4'd4, 8'h00, 8'h5A, 8'hA5, 1, 0, "read_a_ph1");
        run_access(0, 0, 1, 4'd7, 8'hC3, 8'h00, 8'h00, 3, 0, "write_b_ph3");
        run_access(1, 1, 1, 4'd2, 8'h00, 8'h11, 8'h22, 2, 0, "read_both_ph2");
        run_access(1, 0, 1, 4'd9, 8'h00, 8'h33, 8'hB7, 8, 0, "read_b_ph8");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic sa, sb;
            sa = 1'($urandom);
            sb = sa ? 1'($urandom) : 1'b1;
            run_access(1'($urandom), sa, sb, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       $urandom_range(0, 9), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_held_req();
        run_access(1, 1, 0, 4'd1, 8'h00, 8'h6E, 8'h00, 5, 30, "held_req");
        run_access(0, 1, 0, 4'd3, 8'h9D, 8'h00, 8'h00, 6, 0, "after_held");
    endtask

    task automatic test_no_select();
        int hits = 0;
        cpu_req = 1; cpu_sel_a = 0; cpu_sel_b = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (vma === 1'b1 || cia_strobe === 1'b1 || cpu_ack === 1'b1 || fsm_state !== ST_IDLE) hits++;
        end
        cpu_req = 0;
        total++;
        if (hits != 0) begin bad++; $display("FAIL no_select activity got=%0d exp=0", hits); end
    endtask

    task automatic test_drop_mid();
        int d, p, strobe_k, strobes, acks;
        logic [7:0] ra;
        strobe_k = -1; strobes = 0; acks = 0;
        p = $urandom_range(0, 9);
        ra = 8'($urandom);
        wait_phase(p);
        cpu_req = 1; cpu_rw = 1; cpu_sel_a = 1; cpu_sel_b = 0; cia_rdata_a = ra;
        d = sync_delay(p);
        for (int k = 1; k <= d + 10; k++) begin
            step();
            if (vma === 1'b1) cpu_req = 0;
            if (cia_strobe === 1'b1) begin strobes++; strobe_k = k; end
            if (cpu_ack === 1'b1) acks++;
        end
        last_rdata = ra;
        total += 4;
        if (strobes != 1 || strobe_k != d + 6) begin bad++; $display("FAIL drop_mid strobe got=%0d@%0d exp=1@%0d", strobes, strobe_k, d + 6); end
        if (acks != 0) begin bad++; $display("FAIL drop_mid ack got=%0d exp=0", acks); end
        if (cpu_rdata !== ra) begin bad++; $display("FAIL drop_mid rdata got=%h exp=%h", cpu_rdata, ra); end
        if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL drop_mid state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_reset_access();
        wait_phase(2);
        cpu_req = 1; cpu_rw = 0; cpu_sel_a = 0; cpu_sel_b = 1; cpu_rs = 4'd5; cpu_wdata = 8'h77;
        for (int k = 1; k <= 7; k++) step();
        reset = 1;
        #1;
        total += 2;
        if (cia_strobe !== 1'b0) begin bad++; $display("FAIL reset_access strobe got=%b exp=0", cia_strobe); end
        if (vma !== 1'b1) begin bad++; $display("FAIL reset_access in_access vma got=%b exp=1", vma); end
        step();
        total += 3;
        if ({vma, cia_a_en, cia_b_en, cia_strobe, cpu_ack, cpu_berr} !== 6'b0) begin
            bad++; $display("FAIL reset_access ctrl got=%b exp=000000", {vma, cia_a_en, cia_b_en, cia_strobe, cpu_ack, cpu_berr});
        end
        if (cia_rw !== 1'b1 || {cia_rs, cia_wdata, cpu_rdata} !== 20'd0) begin
            bad++; $display("FAIL reset_access data got=%b/%h exp=1/0", cia_rw, {cia_rs, cia_wdata, cpu_rdata});
        end
        if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_access state got=%0d exp=0", fsm_state); end
        reset = 0; cpu_req = 0;
        last_rdata = 8'd0;
        step();
        total++;
        if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_access late_ack got=%b exp=0", cpu_ack); end
    endtask

    task automatic test_eclk_dead();
        int berrs, berr_k, strobes, vmas;
        berrs = 0; berr_k = -1; strobes = 0; vmas = 0;
        dead = 1;
        step();
        cpu_req = 1; cpu_rw = 1; cpu_sel_a = 1; cpu_sel_b = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cpu_berr === 1'b1) begin berrs++; berr_k = k; end
            if (cia_strobe === 1'b1) strobes++;
            if (vma === 1'b1) vmas++;
        end
        total += 3;
        if (strobes != 0 || vmas != 0) begin bad++; $display("FAIL eclk_dead bus_activity got=%0d/%0d exp=0/0", strobes, vmas); end
`ifdef CIA_TIMEOUT_EN
        if (berrs != 1 || berr_k != TIMEOUT_CYCLES) begin bad++; $display("FAIL eclk_dead berr got=%0d@%0d exp=1@%0d", berrs, berr_k, TIMEOUT_CYCLES); end
        if (fsm_state !== ST_DONE) begin bad++; $display("FAIL eclk_dead state got=%0d exp=%0d", fsm_state, ST_DONE); end
`else
        if (berrs != 0) begin bad++; $display("FAIL eclk_dead berr got=%0d exp=0", berrs); end
        if (fsm_state !== ST_SYNC) begin bad++; $display("FAIL eclk_dead state got=%0d exp=%0d", fsm_state, ST_SYNC); end
`endif
        cpu_req = 0; dead = 0; reset = 1;
        step(); step();
        reset = 0;
        last_rdata = 8'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_held_req();
        test_no_select();
        test_drop_mid();
        test_reset_access();
        test_eclk_dead();
        run_access(1, 0, 1, 4'd15, 8'h00, 8'h01, 8'hE4, 0, 0, "after_dead");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
